// File: rtl/etl_dna_pkg.sv
// Shared definitions for the device-DNA access controller: defaults, FSM encoding
// and the DNA_PORTE2 simulation value.
package etl_dna_pkg;

  localparam int DNA_LENGTH_DEFAULT = 96;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_SERVE  = 3'd4
  } dna_state_e;

  localparam logic [95:0] SIM_DNA_VALUE = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;

endpackage

// File: rtl/dna_access_ctrl_arbiter.sv
// Round-robin arbiter sharing the cached DNA between requesters; the pointer
// moves past the granted index only when the grant is consumed.
module dna_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  logic [PW-1:0]      ptr_r;
  logic [PW-1:0]      sel_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               found_s;
  logic               hit_s;
  int                 idx_s;

  // first active request at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    grant_s = '0;
    sel_s   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = int'(ptr_r) + i;
      if (idx_s >= NUM_REQ) begin
        idx_s = idx_s - NUM_REQ;
      end else begin
        idx_s = idx_s;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        hit_s      = !found_s && req[j] && (j == idx_s);
        grant_s[j] = grant_s[j] | hit_s;
        if (hit_s) begin
          sel_s   = PW'(j);
          found_s = 1'b1;
        end else begin
          sel_s   = sel_s;
        end
      end
    end
  end

  // priority pointer: granted index + 1, wrapping to 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (advance) begin
      if (sel_s == PTR_LAST) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= sel_s + PW'(1);
      end
    end
  end

  assign grant       = grant_s;
  assign grant_valid = found_s;

endmodule

// File: rtl/dna_access_ctrl.sv
// DNA_PORTE2 sequencer: loads and shifts out the device DNA, caches it and
// serves it to NUM_REQ requesters, flagging any re-read that disagrees.
module dna_access_ctrl
  import etl_dna_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DNA_LENGTH = DNA_LENGTH_DEFAULT,
  parameter bit AUTO_READ  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DNA_LENGTH-1:0] dna,
  input  logic                  refresh,
  output logic                  dna_valid,
  output logic                  busy,
  output logic                  dna_mismatch,
  output logic                  prim_read,
  output logic                  prim_shift,
  input  logic                  prim_dout
);

  localparam int CW = $clog2(DNA_LENGTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DNA_LENGTH - 1);

  dna_state_e            state_r;
  logic [CW-1:0]         bit_cnt_r;
  logic [DNA_LENGTH-1:0] shift_r;
  logic [DNA_LENGTH-1:0] cache_r;
  logic [DNA_LENGTH-1:0] dna_r;
  logic [NUM_REQ-1:0]    ack_r;
  logic                  pend_r;
  logic                  dna_valid_r;
  logic                  busy_r;
  logic                  mismatch_r;
  logic                  prim_read_r;
  logic                  prim_shift_r;

  logic [NUM_REQ-1:0]    grant_s;
  logic                  grant_valid_s;
  logic                  rd_start_s;
  logic                  advance_s;

  // a read wins over serving: latched refresh, live refresh, or demand with an empty cache
  always_comb begin
    rd_start_s = pend_r | refresh | ((|req) & ~dna_valid_r);
    if (state_r == ST_IDLE) begin
      advance_s = ~rd_start_s & dna_valid_r & grant_valid_s;
    end else begin
      advance_s = 1'b0;
    end
  end

  dna_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .advance    (advance_s),
    .grant      (grant_s),
    .grant_valid(grant_valid_s)
  );

  // sequencing FSM with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      cache_r     <= '0;
      dna_r       <= '0;
      ack_r       <= '0;
      pend_r      <= AUTO_READ;
      dna_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      mismatch_r  <= 1'b0;
      prim_read_r <= 1'b0;
    end else begin
      ack_r       <= '0;
      prim_read_r <= 1'b0;
      // refreshes seen mid-read stay latched so they trigger one more read after COMMIT
      if (refresh) begin
        pend_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (rd_start_s) begin
            state_r     <= ST_LOAD;
            prim_read_r <= 1'b1;
            busy_r      <= 1'b1;
            pend_r      <= 1'b0;
          end else if (advance_s) begin
            state_r <= ST_SERVE;
            ack_r   <= grant_s;
            dna_r   <= cache_r;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_r   <= ST_SHIFT;
          bit_cnt_r <= '0;
        end
        ST_SHIFT: begin
          shift_r <= {shift_r[DNA_LENGTH-2:0], prim_dout};
          if (bit_cnt_r == CNT_LAST) begin
            state_r <= ST_COMMIT;
          end else begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
          end
        end
        ST_COMMIT: begin
          if (dna_valid_r && (shift_r != cache_r)) begin
            mismatch_r <= 1'b1;
          end
          cache_r     <= shift_r;
          dna_valid_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        ST_SERVE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // SHIFT is launched on the falling edge so it is stable around every rising edge
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prim_shift_r <= 1'b0;
    end else begin
      prim_shift_r <= (state_r == ST_SHIFT);
    end
  end

  assign ack          = ack_r;
  assign dna          = dna_r;
  assign dna_valid    = dna_valid_r;
  assign busy         = busy_r;
  assign dna_mismatch = mismatch_r;
  assign prim_read    = prim_read_r;
  assign prim_shift   = prim_shift_r;

endmodule
